// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared constants and types for the ID-stage hazard scoreboard.
//   NREG_DEF / AW_DEF / LAT_W_DEF : default register-file geometry
//   LAT_ALU / LAT_LOAD            : producer latencies until a forwarding bus is reached
//   stop_e                        : stall decision (NoStop / Stop)
package id_hazard_scoreboard_pkg;

  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned LAT_W_DEF = 3;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

  typedef enum logic {
    NoStop = 1'b0,
    Stop   = 1'b1
  } stop_e;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Interface between the ID decode stage and the hazard scoreboard.
//   master : ID stage; drives sources, destination, hold/flush; sees stall results
//   slave  : scoreboard; consumes decode info, returns stall/issue/busy/perf count
interface id_hazard_scoreboard_if
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned LAT_W = LAT_W_DEF,
  parameter int unsigned CNT_W = 32
);

  logic [NSRC-1:0]    src_en;
  logic [NSRC*AW-1:0] src_addr;
  logic               issue_valid;
  logic               dst_we;
  logic [AW-1:0]      dst_addr;
  logic [LAT_W-1:0]   dst_lat;
  logic               hold;
  logic               flush;
  logic               stallreq;
  logic [NSRC-1:0]    stall_src;
  logic [NREG-1:0]    busy_vec;
  logic               issue_fire;
  logic [CNT_W-1:0]   stall_cycles;

  modport master (
    output src_en, src_addr, issue_valid, dst_we, dst_addr, dst_lat, hold, flush,
    input  stallreq, stall_src, busy_vec, issue_fire, stall_cycles
  );

  modport slave (
    input  src_en, src_addr, issue_valid, dst_we, dst_addr, dst_lat, hold, flush,
    output stallreq, stall_src, busy_vec, issue_fire, stall_cycles
  );

endinterface

// File: rtl/id_lat_counter.sv
// Per-register result-latency counter.
//   clk, rst (async, active-low)
//   hold_i     : freeze the counter
//   load_i     : load load_val_i (takes priority over decrement)
//   load_val_i : latency of the newly issued producer
//   cnt_o      : remaining cycles until the result is forwardable
//   busy_o     : cnt_o != 0
module id_lat_counter #(
  parameter int unsigned LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold_i,
  input  logic             load_i,
  input  logic [LAT_W-1:0] load_val_i,
  output logic [LAT_W-1:0] cnt_o,
  output logic             busy_o
);

  logic [LAT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard.
//   clk, rst (async, active-low)
//   bus (slave) : decode sources/destination, hold/flush in; stallreq, stall_src,
//                 issue_fire, busy_vec and stall_cycles perf counter out
// Each architectural register (except r0) has a latency counter; a source whose
// counter is nonzero stalls ID.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned NSRC  = 2,
  parameter int unsigned LAT_W = LAT_W_DEF,
  parameter int unsigned CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave bus
);

  logic [LAT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  busy;
  logic [NSRC-1:0]  stall_src;
  stop_e            stall_state;
  logic             stallreq;
  logic             issue_fire;
  logic [CNT_W-1:0] stall_cycles_d, stall_cycles_q;

  // r0 is hardwired zero, so it never carries a hazard.
  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic load;
    assign load = issue_fire & bus.dst_we & (bus.dst_addr == AW'(r));

    id_lat_counter #(
      .LAT_W(LAT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .hold_i    (bus.hold),
      .load_i    (load),
      .load_val_i(bus.dst_lat),
      .cnt_o     (cnt[r]),
      .busy_o    (busy[r])
    );
  end

  // Sources are checked against current (pre-issue) counters, so an instruction
  // reading its own destination only waits for older producers.
  always_comb begin
    logic [AW-1:0] addr;
    addr      = '0;
    stall_src = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      addr         = bus.src_addr[i*AW +: AW];
      stall_src[i] = bus.src_en[i] & bus.issue_valid & (addr != '0) & (cnt[addr] != '0);
    end
  end

  always_comb begin
    stall_state = NoStop;
    if (|stall_src && !bus.flush) begin
      stall_state = Stop;
    end
  end

  assign stallreq   = (stall_state == Stop);
  assign issue_fire = bus.issue_valid & ~stallreq & ~bus.flush & ~bus.hold;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stallreq && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stallreq     = stallreq;
  assign bus.stall_src    = stall_src;
  assign bus.busy_vec     = busy;
  assign bus.issue_fire   = issue_fire;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Scoreboard bench for id_hazard_scoreboard: the driver pushes hand-computed
// expectations per cycle; the monitor pops and compares on the falling edge.
module tb_id_hazard_scoreboard;
  import id_hazard_scoreboard_pkg::*;

  localparam int unsigned CW = 3;

  typedef struct packed {
    logic          st;
    logic [1:0]    ss;
    logic          fi;
    logic [31:0]   bv;
    logic [CW-1:0] sc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  id_hazard_scoreboard_if #(.CNT_W(CW)) bus ();

  id_hazard_scoreboard #(
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input bit rs, input bit iv, input bit [1:0] se,
                     input bit [4:0] s0, input bit [4:0] s1, input bit we, input bit [4:0] da,
                     input bit [2:0] lat, input bit hd, input bit fl,
                     input bit e_st, input bit [1:0] e_ss, input bit e_fi,
                     input bit [31:0] e_bv, input bit [CW-1:0] e_sc);
    exp_t e;
    @(posedge clk);
    #1;
    rst             = rs;
    bus.issue_valid = iv;
    bus.src_en      = se;
    bus.src_addr    = {s1, s0};
    bus.dst_we      = we;
    bus.dst_addr    = da;
    bus.dst_lat     = lat;
    bus.hold        = hd;
    bus.flush       = fl;
    e.st = e_st; e.ss = e_ss; e.fi = e_fi; e.bv = e_bv; e.sc = e_sc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle.
  initial begin
    exp_t  e;
    exp_t  a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a.st = bus.stallreq; a.ss = bus.stall_src; a.fi = bus.issue_fire;
        a.bv = bus.busy_vec; a.sc = bus.stall_cycles;
        n_cmp++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: got stall=%b src=%b fire=%b busy=%h cyc=%0d, want stall=%b src=%b fire=%b busy=%h cyc=%0d",
                   nm, a.st, a.ss, a.fi, a.bv, a.sc, e.st, e.ss, e.fi, e.bv, e.sc);
        end
      end
    end
  end

  initial begin
    bus.issue_valid = 1'b0;
    bus.src_en      = '0;
    bus.src_addr    = '0;
    bus.dst_we      = 1'b0;
    bus.dst_addr    = '0;
    bus.dst_lat     = '0;
    bus.hold        = 1'b0;
    bus.flush       = 1'b0;

    //  name           rs iv se    s0 s1 we da lat hd fl | st ss    fi bv            sc
    cyc("reset",        0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h0,        0);
    // load r3 then dependent reader: one stall
    cyc("ld_r3",        1, 1, 2'b00, 0, 0, 1, 3, 1, 0, 0,  0, 2'b00, 1, 32'h0,        0);
    cyc("rd_r3_stall",  1, 1, 2'b01, 3, 0, 0, 0, 0, 0, 0,  1, 2'b01, 0, 32'h8,        0);
    cyc("rd_r3_fire",   1, 1, 2'b01, 3, 0, 0, 0, 0, 0, 0,  0, 2'b00, 1, 32'h0,        1);
    // ALU producer: never busy
    cyc("alu_r5",       1, 1, 2'b00, 0, 0, 1, 5, 0, 0, 0,  0, 2'b00, 1, 32'h0,        1);
    cyc("rd_r5",        1, 1, 2'b01, 5, 0, 0, 0, 0, 0, 0,  0, 2'b00, 1, 32'h0,        1);
    // load r7, three held cycles plus one
    cyc("ld_r7",        1, 1, 2'b00, 0, 0, 1, 7, 1, 0, 0,  0, 2'b00, 1, 32'h0,        1);
    cyc("hold1",        1, 1, 2'b10, 0, 7, 0, 0, 0, 1, 0,  1, 2'b10, 0, 32'h80,       1);
    cyc("hold2",        1, 1, 2'b10, 0, 7, 0, 0, 0, 1, 0,  1, 2'b10, 0, 32'h80,       2);
    cyc("hold3",        1, 1, 2'b10, 0, 7, 0, 0, 0, 1, 0,  1, 2'b10, 0, 32'h80,       3);
    cyc("post_hold",    1, 1, 2'b10, 0, 7, 0, 0, 0, 0, 0,  1, 2'b10, 0, 32'h80,       4);
    cyc("rd_r7_fire",   1, 1, 2'b10, 0, 7, 0, 0, 0, 0, 0,  0, 2'b00, 1, 32'h0,        5);
    // r0 never tracked
    cyc("wr_r0",        1, 1, 2'b00, 0, 0, 1, 0, 7, 0, 0,  0, 2'b00, 1, 32'h0,        5);
    cyc("rd_r0",        1, 1, 2'b11, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 1, 32'h0,        5);
    // reload r4 at cnt=2 with lat 5; it must stay busy past where 2 would expire
    cyc("ld_r4",        1, 1, 2'b00, 0, 0, 1, 4, 3, 0, 0,  0, 2'b00, 1, 32'h0,        5);
    cyc("r4_at3",       1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h10,       5);
    cyc("r4_reload",    1, 1, 2'b00, 0, 0, 1, 4, 5, 0, 0,  0, 2'b00, 1, 32'h10,       5);
    cyc("r4_at5",       1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h10,       5);
    cyc("r4_at4",       1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h10,       5);
    cyc("r4_at3b",      1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h10,       5);
    cyc("rst_mid",      0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h0,        0);
    cyc("post_rst",     1, 1, 2'b01, 4, 0, 0, 0, 0, 0, 0,  0, 2'b00, 1, 32'h0,        0);
    // source == destination uses the pre-issue counter
    cyc("self_dep",     1, 1, 2'b01, 9, 0, 1, 9, 1, 0, 0,  0, 2'b00, 1, 32'h0,        0);
    cyc("flush_stall",  1, 1, 2'b01, 9, 0, 0, 0, 0, 0, 1,  0, 2'b01, 0, 32'h200,      0);
    cyc("idle",         1, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0,  0, 2'b00, 0, 32'h0,        0);
    // perf counter saturation (3-bit counter)
    cyc("ld_r10",       1, 1, 2'b00, 0, 0, 1, 10, 7, 0, 0, 0, 2'b00, 1, 32'h0,        0);
    cyc("ld_r11",       1, 1, 2'b00, 0, 0, 1, 11, 7, 0, 0, 0, 2'b00, 1, 32'h400,      0);
    for (int k = 0; k < 10; k++) begin
      cyc("sat",        1, 1, 2'b01, 11, 10, 0, 0, 0, 1, 0, 1, 2'b01, 0, 32'hC00,
          (k > 7) ? CW'(7) : CW'(k));
    end
    cyc("sat_flush",    1, 1, 2'b01, 11, 10, 0, 0, 0, 0, 1, 0, 2'b01, 0, 32'hC00,     7);

    // Let the monitor drain, bounded.
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_scoreboard.md
ID_HAZARD_SCOREBOARD -- requirements
Module: id_hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers.
REQ-002 SHALL have parameter AW, default 5, register address width (= clog2(NREG)).
REQ-003 SHALL have parameter NSRC, default 2, number of source operands checked per instruction.
REQ-004 SHALL have parameter LAT_W, default 3, width of per-register latency counter.
REQ-005 SHALL have parameter CNT_W, default 32, width of stall-cycle performance counter.
REQ-006 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port src_en  input  NSRC  per-source "operand is read" flag from ID decode.
REQ-009 SHALL have port src_addr  input  NSRC*AW  packed source register addresses, source 0 in LSBs.
REQ-010 SHALL have port issue_valid  input  1  ID holds a valid decoded instruction.
REQ-011 SHALL have port dst_we  input  1  instruction writes a register.
REQ-012 SHALL have port dst_addr  input  AW  destination register.
REQ-013 SHALL have port dst_lat  input  LAT_W  cycles until result reaches a forwarding bus (0 = ALU, 1 = load).
REQ-014 SHALL have port hold  input  1  downstream (EX and later) frozen this cycle.
REQ-015 SHALL have port flush  input  1  discard instruction currently in ID.
REQ-016 SHALL have port stallreq  output  1  ID must stall this cycle.
REQ-017 SHALL have port stall_src  output  NSRC  one bit per source causing stallreq.
REQ-018 SHALL have port busy_vec  output  NREG  register r has nonzero counter.
REQ-019 SHALL have port issue_fire  output  1  instruction accepted this cycle.
REQ-020 SHALL have port stall_cycles  output  CNT_W  count of cycles with stallreq high.

Function
REQ-021 SHALL keep one LAT_W counter cnt[r] per register r in 1..NREG-1; register 0 never tracked, busy_vec[0] constant 0.
REQ-022 stall_src[i] SHALL be combinational: src_en[i] & issue_valid & (src_addr[i] != 0) & (cnt[src_addr[i]] != 0).
REQ-023 stallreq SHALL be OR of stall_src, forced 0 when flush is high.
REQ-024 issue_fire SHALL equal issue_valid & ~stallreq & ~flush & ~hold.
REQ-025 When hold is high, all counters SHALL hold value and no issue SHALL be recorded.
REQ-026 When hold is low, every nonzero counter SHALL decrement by 1 per cycle, never below 0.
REQ-027 On issue_fire with dst_we and dst_addr != 0, cnt[dst_addr] SHALL load dst_lat next cycle, overriding that register's decrement.
REQ-028 dst_lat = 0 SHALL leave cnt[dst_addr] at 0 (result forwardable next cycle, no stall).
REQ-029 Source equal to destination of same instruction SHALL be checked against pre-issue counter value.
REQ-030 flush SHALL not clear existing counters (older in-flight producers still complete).
REQ-031 stall_cycles SHALL increment by 1 each cycle stallreq is high and saturate at all-ones.
REQ-032 busy_vec SHALL be registered counter state (cnt != 0), zero latency relative to counters.

Reset
REQ-033 On rst low, all counters, busy_vec and stall_cycles SHALL clear to 0 immediately, asynchronously; stallreq, stall_src, issue_fire then 0.
REQ-034 Reset asserted mid-countdown SHALL discard all pending hazards; first cycle after release SHALL show no stall.

Structure
REQ-035 Shared defines header SHALL hold default NREG, AW, LAT_W, and latency constants LAT_ALU=0, LAT_LOAD=1, alongside existing Stop/NoStop values.
REQ-036 One sub-module SHALL be used: id_lat_counter (single-register load/decrement/hold counter), instantiated NREG-1 times by generate.
REQ-037 No other submodules; source comparison and stall OR SHALL be in top module.

Verification
REQ-038 Load r3 (dst_lat=1) issued, next instr reads r3 -> stallreq=1 one cycle, stall_src=01, then issue_fire=1; stall_cycles=1.
REQ-039 ALU writes r5 (dst_lat=0), next reads r5 -> no stall, busy_vec[5]=0 throughout.
REQ-040 Load r7 then hold=1 for 3 cycles, dependent reader -> stallreq high for all 3 hold cycles plus 1, busy_vec[7] clears only after hold drops.
REQ-041 Write to r0 with dst_lat=7, reader of r0 -> no stall, busy_vec=0.
REQ-042 r4 counter at 2, new issue to r4 with dst_lat=5 same cycle -> cnt[4]=5 next cycle; rst pulse low mid-count -> busy_vec=0 immediately.
REQ-043 Force stall_cycles to all-ones-1, two stall cycles -> value saturates at all-ones; flush during stall -> stallreq=0, issue_fire=0.
